// File: rtl/uart_echo_engine.sv
// Echo controller between a uart RX FIFO read side and TX FIFO write side.
// Immediate mode echoes each byte; line mode buffers up to a terminator and replays the line.
module uart_echo_engine #(
    parameter int              DBIT       = 8,
    parameter int              DEPTH_LOG2 = 4,
    parameter logic [DBIT-1:0] TERM       = 8'h0D
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic            busy,
    output logic            overflow,
    output logic [15:0]     echo_count
);

    localparam int                    DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        PUSH   = 2'd2,
        REPLAY = 2'd3
    } state_t;

    state_t                state;
    logic                  mode_q;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DBIT-1:0]       hold;
    logic [DBIT-1:0]       line_buf [DEPTH];

    function automatic logic is_term(input logic [DBIT-1:0] b);
        return (b == TERM);
    endfunction

    assign rd_uart = (state == POP);
    assign busy    = (state != IDLE);
    // wr_uart reacts to tx_full in the same cycle so a stall never loses or repeats a byte
    assign wr_uart = ((state == PUSH) || (state == REPLAY)) && !tx_full;

    always_comb begin
        w_data = '0;
        case (state)
            PUSH:    w_data = hold;
            REPLAY:  w_data = line_buf[rd_ptr];
            default: w_data = '0;
        endcase
    end

    // Line storage: written only while popping in line mode, never cleared
    always_ff @(posedge clk) begin
        if (!rst && (state == POP) && mode_q) begin
            line_buf[wr_ptr] <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hold       <= '0;
            overflow   <= 1'b0;
            echo_count <= '0;
        end else begin
            if (wr_uart) begin
                echo_count <= echo_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        mode_q <= mode;
                        state  <= POP;
                    end
                end
                POP: begin
                    hold <= r_data;
                    if (!mode_q) begin
                        state <= PUSH;
                    end else if (is_term(r_data)) begin
                        rd_ptr <= '0;
                        state  <= REPLAY;
                    end else if (wr_ptr == LAST) begin
                        // Buffer full without a terminator: flush what we have
                        overflow <= 1'b1;
                        rd_ptr   <= '0;
                        state    <= REPLAY;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        state  <= IDLE;
                    end
                end
                PUSH: begin
                    if (!tx_full) begin
                        state <= IDLE;
                    end
                end
                REPLAY: begin
                    if (!tx_full) begin
                        if (rd_ptr == wr_ptr) begin
                            rd_ptr <= '0;
                            wr_ptr <= '0;
                            state  <= IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench for uart_echo_engine: models the RX FIFO, logs every TX push
// with its cycle number and compares against hand-computed expectations.
module tb_uart_echo_engine;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        busy;
    logic        overflow;
    logic [15:0] echo_count;

    uart_echo_engine #(.DBIT(8), .DEPTH_LOG2(4), .TERM(8'h0D)) dut (
        .clk(clk), .rst(rst), .mode(mode), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .busy(busy), .overflow(overflow), .echo_count(echo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RX FIFO model, first-word-fall-through
    logic [7:0] rx_mem [64];
    logic [5:0] rx_head;
    logic [5:0] rx_tail;
    assign rx_empty = (rx_head == rx_tail);
    assign r_data   = rx_mem[rx_head];

    int cyc;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_uart) rx_head <= rx_head + 6'd1;
    end

    logic [7:0] tx_log [256];
    int         tx_cyc [256];
    int         tx_n;
    int         last_rd_cyc;
    always @(negedge clk) begin
        if (rd_uart) last_rd_cyc = cyc;
        if (wr_uart) begin
            tx_log[tx_n[7:0]] = w_data;
            tx_cyc[tx_n[7:0]] = cyc;
            tx_n = tx_n + 1;
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_mem[rx_tail] = b;
        rx_tail = rx_tail + 6'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;
    int c0;
    int e0;
    int k;

    initial begin
        n_checks = 0; n_fail = 0; tx_n = 0; last_rd_cyc = 0;
        cyc = 0; rx_head = '0; rx_tail = '0;
        rst = 1'b1; mode = 1'b0; tx_full = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_rd_uart", 32'(rd_uart), 32'd0);
        check("rst_wr_uart", 32'(wr_uart), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_echo_count", 32'(echo_count), 32'd0);

        // Immediate echo latency
        base = tx_n; c0 = cyc;
        rx_push(8'h41);
        tick(4);
        check("t1_push_cnt", 32'(tx_n - base), 32'd1);
        check("t1_data", 32'(tx_log[base[7:0]]), 32'h41);
        check("t1_rd_latency", 32'(last_rd_cyc - c0), 32'd1);
        check("t1_wr_latency", 32'(tx_cyc[base[7:0]] - c0), 32'd2);
        check("t1_echo_count", 32'(echo_count), 32'd1);

        // TX backpressure
        base = tx_n;
        tx_full = 1'b1;
        rx_push(8'h55);
        tick(10);
        check("t2_stall_wr", 32'(wr_uart), 32'd0);
        check("t2_stall_busy", 32'(busy), 32'd1);
        check("t2_stall_cnt", 32'(tx_n - base), 32'd0);
        tx_full = 1'b0;
        tick(3);
        check("t2_push_cnt", 32'(tx_n - base), 32'd1);
        check("t2_data", 32'(tx_log[base[7:0]]), 32'h55);
        check("t2_echo_count", 32'(echo_count), 32'd2);

        // Line echo with terminator
        base = tx_n; mode = 1'b1;
        rx_push(8'h41); rx_push(8'h42); rx_push(8'h0D);
        tick(15);
        check("t3_push_cnt", 32'(tx_n - base), 32'd3);
        check("t3_d0", 32'(tx_log[base[7:0]]), 32'h41);
        check("t3_d1", 32'(tx_log[8'(base + 1)]), 32'h42);
        check("t3_d2", 32'(tx_log[8'(base + 2)]), 32'h0D);
        check("t3_after_term", 32'(tx_cyc[base[7:0]] - last_rd_cyc), 32'd1);
        check("t3_consec1", 32'(tx_cyc[8'(base + 1)] - tx_cyc[base[7:0]]), 32'd1);
        check("t3_consec2", 32'(tx_cyc[8'(base + 2)] - tx_cyc[8'(base + 1)]), 32'd1);
        check("t3_echo_count", 32'(echo_count), 32'd5);

        // Overflow: 17 bytes containing no terminator value
        base = tx_n;
        for (int i = 0; i < 17; i++) rx_push(8'(8'h40 + i));
        tick(31);
        check("t4_ovf_before", 32'(overflow), 32'd0);
        check("t4_16th_pop", 32'(rd_uart), 32'd1);
        tick(1);
        check("t4_ovf_after", 32'(overflow), 32'd1);
        tick(30);
        check("t4_push_cnt", 32'(tx_n - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            k = base + i;
            check($sformatf("t4_d%0d", i), 32'(tx_log[k[7:0]]), 32'(8'h40 + i));
        end
        check("t4_echo_count", 32'(echo_count), 32'd21);
        rx_push(8'h0D);
        tick(8);
        check("t4_newline_cnt", 32'(tx_n - base), 32'd18);
        check("t4_newline_d0", 32'(tx_log[8'(base + 16)]), 32'h50);
        check("t4_newline_d1", 32'(tx_log[8'(base + 17)]), 32'h0D);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-replay after two pushes
        base = tx_n;
        rx_push(8'h61); rx_push(8'h62); rx_push(8'h63); rx_push(8'h64); rx_push(8'h0D);
        k = 0;
        while ((tx_n - base) < 2 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("t5_reach_replay", 32'(tx_n - base), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_rd_uart", 32'(rd_uart), 32'd0);
        check("t5_wr_uart", 32'(wr_uart), 32'd0);
        check("t5_w_data", 32'(w_data), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_echo_count", 32'(echo_count), 32'd0);
        tick(10);
        check("t5_no_more_push", 32'(tx_n - base), 32'd2);
        check("t5_d0", 32'(tx_log[base[7:0]]), 32'h61);
        check("t5_d1", 32'(tx_log[8'(base + 1)]), 32'h62);

        // Counter wrap; mode toggled while PUSH is stalled
        force dut.echo_count = 16'hFFFF;
        tick(1);
        release dut.echo_count;
        base = tx_n; mode = 1'b0; tx_full = 1'b1;
        rx_push(8'h7E);
        tick(3);
        mode = 1'b1;
        tick(2);
        check("t6_stall_busy", 32'(busy), 32'd1);
        tx_full = 1'b0;
        tick(3);
        check("t6_push_cnt", 32'(tx_n - base), 32'd1);
        check("t6_data", 32'(tx_log[base[7:0]]), 32'h7E);
        check("t6_wrap", 32'(echo_count), 32'd0);
        e0 = 0;
        rx_push(8'h0D);
        tick(6);
        check("t6_line_only_term", 32'(tx_n - base), 32'd2);
        check("t6_term_data", 32'(tx_log[8'(base + 1)]), 32'h0D);
        check("t6_echo_after_wrap", 32'(echo_count), 32'(e0 + 1));
        check("t6_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
